piso_shift_transmitter: RTL

Parallel-in, serial-out shift transmitter. Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per bit period. A bit strobe tells downstream serial-in shift-register receivers when to sample. By default it sends MSB first, so a receiver that shifts into bit 0 toward the MSB reconstructs the word unchanged after WIDTH strobes.

---
 rtl/piso_pkg.sv | 24 ++
 rtl/piso_shift_transmitter_bit_tick_gen.sv | 48 ++++
 rtl/piso_shift_transmitter.sv | 126 ++++++++++++
 3 files changed

// File: rtl/piso_pkg.sv
// Shared definitions for the PISO shift transmitter.
// Contents:
//   piso_state_e : transmitter state (IDLE = no frame, SHIFT = frame in progress)
//   cnt_width()  : counter width helper, max(1, $clog2(n)), usable in localparams
package piso_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } piso_state_e;

  // A counter for a range of 1 still needs one bit, so clamp $clog2 at 1.
  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n);
    if (w < 1) begin
      w = 1;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage

// File: rtl/piso_shift_transmitter_bit_tick_gen.sv
// Bit-period divider for the PISO shift transmitter.
// Counts clk cycles within one bit period and flags the last one.
// Ports:
//   clk   in  : clock, rising edge
//   reset in  : asynchronous, active-high
//   clear in  : restart the period at count 0 (word accepted)
//   run   in  : count while a frame is in progress
//   tick  out : high on the last cycle of each bit period while running
module bit_tick_gen
  import piso_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic tick
);

  localparam int DW = cnt_width(DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [DW-1:0] CNT_ONE  = DW'(1);
  localparam logic [DW-1:0] CNT_ZERO = DW'(0);

  logic [DW-1:0] r_div_cnt;

  // Cycle-within-bit counter; clear wins so a new word always starts a fresh period.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div_cnt <= CNT_ZERO;
    end else if (clear) begin
      r_div_cnt <= CNT_ZERO;
    end else if (run) begin
      if (r_div_cnt == DIV_LAST) begin
        r_div_cnt <= CNT_ZERO;
      end else begin
        r_div_cnt <= r_div_cnt + CNT_ONE;
      end
    end else begin
      r_div_cnt <= r_div_cnt;
    end
  end

  // Registered-only path: run comes from the state register upstream.
  assign tick = run && (r_div_cnt == DIV_LAST);

endmodule

// File: rtl/piso_shift_transmitter.sv
// Parallel-in, serial-out shift transmitter.
// Takes a WIDTH-bit word on a valid/ready handshake and shifts it out one
// bit per DIV clk cycles, MSB first when MSB_FIRST=1, LSB first otherwise.
// Ports:
//   clk          in  : clock, rising edge
//   reset        in  : asynchronous, active-high
//   load_valid   in  : load_data valid this cycle
//   load_ready   out : word can be accepted this cycle (registers only)
//   load_data    in  : word to send, sampled on accept
//   serial_out   out : current serial bit (0 when idle)
//   serial_valid out : a frame bit is on serial_out
//   bit_strobe   out : last cycle of each bit period (receiver sample enable)
//   last_bit     out : whole period of the final bit of the frame
module piso_shift_transmitter
  import piso_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int DIV       = 1,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             bit_strobe,
  output logic             last_bit
);

  localparam int BW = cnt_width(WIDTH);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [BW-1:0] BIT_ONE  = BW'(1);
  localparam logic [BW-1:0] BIT_ZERO = BW'(0);

  piso_state_e      r_state;
  piso_state_e      w_state_nxt;
  logic [WIDTH-1:0] r_shift;
  logic [BW-1:0]    r_bit_cnt;

  logic w_run;
  logic w_tick;
  logic w_last;
  logic w_accept;

  assign w_run  = (r_state == SHIFT);
  assign w_last = w_run && (r_bit_cnt == BIT_LAST);

  // Ready in IDLE, or on the very last cycle of a frame so the next word
  // follows with no gap. Never looks at load_valid.
  assign load_ready = (r_state == IDLE) || (w_last && w_tick);
  assign w_accept   = load_valid && load_ready;

  bit_tick_gen #(
    .DIV (DIV)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .clear (w_accept),
    .run   (w_run),
    .tick  (w_tick)
  );

  // Serial outputs are decoded from registers only.
  assign serial_out   = w_run && (MSB_FIRST ? r_shift[WIDTH-1] : r_shift[0]);
  assign serial_valid = w_run;
  assign bit_strobe   = w_tick;
  assign last_bit     = w_last;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; an accept at end of frame keeps SHIFT (back-to-back).
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = SHIFT;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      SHIFT: begin
        if (w_last && w_tick) begin
          w_state_nxt = w_accept ? SHIFT : IDLE;
        end else begin
          w_state_nxt = SHIFT;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Shift register and bit counter; shift toward the output end, zero fill.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shift   <= {WIDTH{1'b0}};
      r_bit_cnt <= BIT_ZERO;
    end else if (w_accept) begin
      r_shift   <= load_data;
      r_bit_cnt <= BIT_ZERO;
    end else if (w_tick) begin
      if (MSB_FIRST) begin
        r_shift <= {r_shift[WIDTH-2:0], 1'b0};
      end else begin
        r_shift <= {1'b0, r_shift[WIDTH-1:1]};
      end
      // Park the counter at zero after the final bit so idle state is clean.
      r_bit_cnt <= w_last ? BIT_ZERO : (r_bit_cnt + BIT_ONE);
    end else begin
      r_shift   <= r_shift;
      r_bit_cnt <= r_bit_cnt;
    end
  end

endmodule
